wb_arb_stage: RTL and testbench

//  Multi-source write-back stage: merges NUM_CH independent result channels (ALU, load, CSR, ...)

---
 rtl/tinyriscv_pkg.sv | 18 +
 rtl/wb_fifo.sv | 90 +++++++++
 rtl/wb_arb_stage.sv | 141 ++++++++++++++
 tb/tb_wb_arb_stage.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyriscv_pkg.sv
// Shared core types: register-file bus widths, the write-back request record
// and the write-back arbitration mode.
package tinyriscv_pkg;

   localparam int unsigned RegAddrBus = 5;   // register address width
   localparam int unsigned RegBus     = 32;  // register data width

   typedef struct packed {
      logic [RegAddrBus-1:0] waddr;
      logic [RegBus-1:0]     wdata;
   } wb_req_t;

   typedef enum logic {
      WB_ARB_FIXED = 1'b0,
      WB_ARB_RR    = 1'b1
   } wb_arb_mode_e;

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO of write-back requests, one per write-back channel.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   flush_i          synchronous clear; overrides push and pop
//   push_i, data_i   enqueue request (ignored when full)
//   pop_i, data_o    dequeue request / current head (ignored when empty)
//   full_o, empty_o  occupancy flags
//   entries_o        raw storage array, for pending-write address matching
//   entry_valid_o    per-slot occupancy, aligned with entries_o
module wb_fifo
   import tinyriscv_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  push_i,
   input  wb_req_t               data_i,
   input  logic                  pop_i,
   output wb_req_t               data_o,
   output logic                  full_o,
   output logic                  empty_o,
   output wb_req_t [Depth-1:0]   entries_o,
   output logic    [Depth-1:0]   entry_valid_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   wb_req_t [Depth-1:0] mem_q;
   logic do_push, do_pop;

   assign full_o    = (cnt_q == CntW'(Depth));
   assign empty_o   = (cnt_q == '0);
   assign do_push   = push_i && !full_o && !flush_i;
   assign do_pop    = pop_i && !empty_o && !flush_i;
   assign data_o    = mem_q[rd_ptr_q];
   assign entries_o = mem_q;

   // Depth need not be a power of two, so wrap explicitly.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
         else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and count.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   // A slot is live when its distance from the read pointer is below the count.
   always_comb begin
      entry_valid_o = '0;
      for (int k = 0; k < int'(Depth); k++) begin
         entry_valid_o[k] =
            (((32'(k) + Depth - 32'(rd_ptr_q)) % Depth) < 32'(cnt_q));
      end
   end

endmodule

// File: rtl/wb_arb_stage.sv
// Multi-source write-back stage: NUM_CH result channels, each buffered by a
// wb_fifo, are arbitrated onto one registered register-file write port.
// Ports:
//   clk_i, rst_i                clock, asynchronous active-high reset
//   flush_i                     drop all queued and output writes
//   ch_valid_i/ch_ready_o       per-channel request handshake
//   ch_waddr_i/ch_wdata_i       per-channel destination register and data
//   query_raddr_i               register to check for in-flight writes
//   query_pending_o             a write to query_raddr_i is still in flight
//   reg_waddr_o/wdata_o/wen_o   registered register-file write port
//   idle_o                      all FIFOs empty and no write on the port
module wb_arb_stage
   import tinyriscv_pkg::*;
#(
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned ARB_MODE   = 0
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                flush_i,
   input  logic [NUM_CH-1:0]                   ch_valid_i,
   output logic [NUM_CH-1:0]                   ch_ready_o,
   input  logic [NUM_CH-1:0][RegAddrBus-1:0]   ch_waddr_i,
   input  logic [NUM_CH-1:0][RegBus-1:0]       ch_wdata_i,
   input  logic [RegAddrBus-1:0]               query_raddr_i,
   output logic                                query_pending_o,
   output logic [RegAddrBus-1:0]               reg_waddr_o,
   output logic [RegBus-1:0]                   reg_wdata_o,
   output logic                                reg_wen_o,
   output logic                                idle_o
);

   localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam wb_arb_mode_e Mode = (ARB_MODE == 1) ? WB_ARB_RR : WB_ARB_FIXED;

   wb_req_t                    fifo_head [NUM_CH];
   wb_req_t [FIFO_DEPTH-1:0]   fifo_ent  [NUM_CH];
   logic    [FIFO_DEPTH-1:0]   fifo_vld  [NUM_CH];
   logic [NUM_CH-1:0]          fifo_full, fifo_empty, fifo_push, grant_oh;

   logic            grant_vld;
   logic [IdxW-1:0] grant_idx;
   wb_req_t         win_req;
   logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
   wb_req_t         out_q, out_d;
   logic            wen_q, wen_d;
   logic            query_hit;

   for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
      wb_req_t push_req;
      assign push_req      = '{waddr: ch_waddr_i[i], wdata: ch_wdata_i[i]};
      assign ch_ready_o[i] = !fifo_full[i] && !flush_i;
      // x0 writes complete the handshake but are discarded here.
      assign fifo_push[i]  = ch_valid_i[i] && ch_ready_o[i] && (ch_waddr_i[i] != '0);

      wb_fifo #(
         .Depth (FIFO_DEPTH)
      ) u_fifo (
         .clk_i         (clk_i),
         .rst_i         (rst_i),
         .flush_i       (flush_i),
         .push_i        (fifo_push[i]),
         .data_i        (push_req),
         .pop_i         (grant_oh[i]),
         .data_o        (fifo_head[i]),
         .full_o        (fifo_full[i]),
         .empty_o       (fifo_empty[i]),
         .entries_o     (fifo_ent[i]),
         .entry_valid_o (fifo_vld[i])
      );
   end

   // Round-robin: first candidate at or above the pointer, else wrap to the
   // lowest candidate. Fixed priority is just the wrap search alone.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      grant_oh  = '0;
      win_req   = '0;
      if (Mode == WB_ARB_RR) begin
         for (int c = 0; c < int'(NUM_CH); c++) begin
            if (!grant_vld && !fifo_empty[c] && (c >= int'(rr_ptr_q))) begin
               grant_vld = 1'b1;
               grant_idx = IdxW'(c);
            end
         end
      end
      for (int c = 0; c < int'(NUM_CH); c++) begin
         if (!grant_vld && !fifo_empty[c]) begin
            grant_vld = 1'b1;
            grant_idx = IdxW'(c);
         end
      end
      for (int c = 0; c < int'(NUM_CH); c++) begin
         if (grant_vld && (grant_idx == IdxW'(c))) begin
            grant_oh[c] = 1'b1;
            win_req     = fifo_head[c];
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      out_d    = out_q;
      wen_d    = 1'b0;
      if (!flush_i && grant_vld) begin
         rr_ptr_d = (grant_idx == IdxW'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
         out_d    = win_req;
         wen_d    = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr_q <= '0;
         out_q    <= '0;
         wen_q    <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         out_q    <= out_d;
         wen_q    <= wen_d;
      end
   end

   always_comb begin
      query_hit = wen_q && (out_q.waddr == query_raddr_i);
      for (int c = 0; c < int'(NUM_CH); c++) begin
         for (int d = 0; d < int'(FIFO_DEPTH); d++) begin
            if (fifo_vld[c][d] && (fifo_ent[c][d].waddr == query_raddr_i)) query_hit = 1'b1;
         end
      end
   end

   assign query_pending_o = query_hit && (query_raddr_i != '0);
   assign reg_waddr_o     = out_q.waddr;
   assign reg_wdata_o     = out_q.wdata;
   assign reg_wen_o       = wen_q;
   assign idle_o          = (&fifo_empty) && !wen_q;

endmodule

// File: tb/tb_wb_arb_stage.sv
module tb_wb_arb_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Fixed-priority instance (f_) and round-robin instance (r_).
   logic            f_flush = 1'b0, r_flush = 1'b0;
   logic [1:0]      f_valid = '0, r_valid = '0, f_ready, r_ready;
   logic [1:0][4:0] f_waddr = '0, r_waddr = '0;
   logic [1:0][31:0] f_wdata = '0, r_wdata = '0;
   logic [4:0]      f_qaddr = '0, r_qaddr = '0;
   logic            f_pending, r_pending, f_wen, r_wen, f_idle, r_idle;
   logic [4:0]      f_raddr, r_raddr;
   logic [31:0]     f_rdata, r_rdata;

   int n_pass = 0;
   int n_total = 0;

   logic [36:0] f_q[$];
   logic [36:0] r_q0[$], r_q1[$];
   int          r_seq[$];

   wb_arb_stage #(.NUM_CH(2), .FIFO_DEPTH(2), .ARB_MODE(0)) u_fix (
      .clk_i(clk), .rst_i(rst), .flush_i(f_flush),
      .ch_valid_i(f_valid), .ch_ready_o(f_ready),
      .ch_waddr_i(f_waddr), .ch_wdata_i(f_wdata),
      .query_raddr_i(f_qaddr), .query_pending_o(f_pending),
      .reg_waddr_o(f_raddr), .reg_wdata_o(f_rdata), .reg_wen_o(f_wen), .idle_o(f_idle)
   );

   wb_arb_stage #(.NUM_CH(2), .FIFO_DEPTH(2), .ARB_MODE(1)) u_rr (
      .clk_i(clk), .rst_i(rst), .flush_i(r_flush),
      .ch_valid_i(r_valid), .ch_ready_o(r_ready),
      .ch_waddr_i(r_waddr), .ch_wdata_i(r_wdata),
      .query_raddr_i(r_qaddr), .query_pending_o(r_pending),
      .reg_waddr_o(r_raddr), .reg_wdata_o(r_rdata), .reg_wen_o(r_wen), .idle_o(r_idle)
   );

   // Scoreboard for the fixed instance: expected writes in retire order.
   always @(negedge clk) begin
      if (!rst && f_wen) begin
         n_total++;
         if (f_q.size() == 0) begin
            $display("FAIL fix_write: got x%0d/%08h, no write expected", f_raddr, f_rdata);
         end else begin
            logic [36:0] e;
            e = f_q.pop_front();
            if ({f_raddr, f_rdata} !== e)
               $display("FAIL fix_write: got x%0d/%08h, expected x%0d/%08h",
                        f_raddr, f_rdata, e[36:32], e[31:0]);
            else n_pass++;
         end
      end
   end

   // Scoreboard for the RR instance: per-channel order, channel from addr[4].
   always @(negedge clk) begin
      if (!rst && r_wen) begin
         logic [36:0] e;
         n_total++;
         r_seq.push_back(int'(r_raddr[4]));
         if (r_raddr[4] == 1'b0 && r_q0.size() != 0) e = r_q0.pop_front();
         else if (r_raddr[4] == 1'b1 && r_q1.size() != 0) e = r_q1.pop_front();
         else e = '1;
         if ({r_raddr, r_rdata} !== e)
            $display("FAIL rr_write: got x%0d/%08h, expected x%0d/%08h",
                     r_raddr, r_rdata, e[36:32], e[31:0]);
         else n_pass++;
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick();
      tick();
      n_total++;
      if ({f_wen, f_raddr, f_rdata} !== 38'd0)
         $display("FAIL reset_port: got wen=%b x%0d/%08h, expected 0/0/0", f_wen, f_raddr, f_rdata);
      else n_pass++;
      n_total++;
      if ({f_ready, f_pending, f_idle} !== 4'b1101)
         $display("FAIL reset_flags: got ready=%b pend=%b idle=%b, expected 11/0/1",
                  f_ready, f_pending, f_idle);
      else n_pass++;
      n_total++;
      if ({r_ready, r_wen, r_idle} !== 4'b1101)
         $display("FAIL reset_rr: got ready=%b wen=%b idle=%b, expected 11/0/1", r_ready, r_wen, r_idle);
      else n_pass++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      f_waddr[0] = 5'd5;
      f_wdata[0] = 32'hDEAD_BEEF;
      f_valid    = 2'b01;
      f_q.push_back({5'd5, 32'hDEAD_BEEF});
      tick();  // accept edge E
      f_valid = '0;
      f_qaddr = 5'd5;
      #1;
      n_total++;
      if (f_wen !== 1'b0) $display("FAIL single_early: got wen=%b, expected 0 after E", f_wen);
      else n_pass++;
      n_total++;
      if (f_pending !== 1'b1) $display("FAIL single_query: got pending=%b, expected 1", f_pending);
      else n_pass++;
      tick();  // E+1
      n_total++;
      if ({f_wen, f_raddr, f_rdata} !== {1'b1, 5'd5, 32'hDEAD_BEEF})
         $display("FAIL single_write: got wen=%b x%0d/%08h, expected 1 x5/deadbeef",
                  f_wen, f_raddr, f_rdata);
      else n_pass++;
      tick();
      n_total++;
      if (f_q.size() != 0) $display("FAIL single_drain: got %0d pending, expected 0", f_q.size());
      else n_pass++;
      f_qaddr = '0;
   endtask

   task automatic test_fixed_contention();
      logic [4:0] exp_a[3];
      exp_a[0] = 5'd1; exp_a[1] = 5'd2; exp_a[2] = 5'd3;
      for (int k = 0; k < 3; k++) f_q.push_back({exp_a[k], 27'd0, exp_a[k]});
      f_waddr[0] = 5'd1; f_wdata[0] = 32'd1;
      f_waddr[1] = 5'd3; f_wdata[1] = 32'd3;
      f_valid = 2'b11;
      tick();
      f_waddr[0] = 5'd2; f_wdata[0] = 32'd2;
      f_valid = 2'b01;
      for (int k = 0; k < 3; k++) begin
         tick();
         f_valid = '0;
         n_total++;
         if ({f_wen, f_raddr} !== {1'b1, exp_a[k]})
            $display("FAIL fixed_order%0d: got wen=%b x%0d, expected 1 x%0d", k, f_wen, f_raddr, exp_a[k]);
         else n_pass++;
      end
      tick();
      n_total++;
      if (f_idle !== 1'b1) $display("FAIL fixed_idle: got %b, expected 1", f_idle);
      else n_pass++;
   endtask

   task automatic test_full_x0();
      logic [4:0] seq[6];
      seq[0] = 5'd10; seq[1] = 5'd11; seq[2] = 5'd12; seq[3] = 5'd13; seq[4] = 5'd20; seq[5] = 5'd21;
      for (int k = 0; k < 6; k++) f_q.push_back({seq[k], 27'd0, seq[k]});
      for (int c = 0; c < 4; c++) begin
         f_waddr[0] = seq[c]; f_wdata[0] = 32'(seq[c]);
         f_valid[0] = 1'b1;
         f_valid[1] = (c < 2);
         if (c < 2) begin
            f_waddr[1] = seq[4 + c]; f_wdata[1] = 32'(seq[4 + c]);
         end else begin
            n_total++;
            if (f_ready !== 2'b01) $display("FAIL full_ready%0d: got %b, expected 01", c, f_ready);
            else n_pass++;
         end
         tick();
      end
      f_valid = '0;
      for (int i = 0; i < 20 && f_ready[1] !== 1'b1; i++) tick();
      n_total++;
      if (f_ready[1] !== 1'b1) $display("FAIL full_reopen: got ready1=%b, expected 1", f_ready[1]);
      else n_pass++;
      f_waddr[1] = 5'd0; f_wdata[1] = 32'd7; f_valid = 2'b10;
      tick();  // x0 accepted here
      f_valid = '0;
      for (int i = 0; i < 20 && f_idle !== 1'b1; i++) tick();
      tick();
      n_total++;
      if (f_idle !== 1'b1 || f_q.size() != 0)
         $display("FAIL full_drain: got idle=%b left=%0d, expected 1/0", f_idle, f_q.size());
      else n_pass++;
   endtask

   task automatic test_flush_query();
      f_q.push_back({5'd8, 32'h88});
      f_waddr[0] = 5'd8; f_wdata[0] = 32'h88; f_valid = 2'b01;
      tick();
      f_waddr[0] = 5'd9; f_wdata[0] = 32'h99;
      tick();
      f_valid = '0;
      f_qaddr = 5'd9;
      #1;
      n_total++;
      if (f_pending !== 1'b1) $display("FAIL flush_pend_before: got %b, expected 1", f_pending);
      else n_pass++;
      f_flush = 1'b1;
      f_waddr[1] = 5'd4; f_wdata[1] = 32'h44; f_valid = 2'b10;
      #1;
      n_total++;
      if (f_ready !== 2'b00) $display("FAIL flush_ready: got %b, expected 00", f_ready);
      else n_pass++;
      tick();
      f_flush = 1'b0; f_valid = '0;
      #1;
      n_total++;
      if ({f_wen, f_pending, f_idle} !== 3'b001)
         $display("FAIL flush_after: got wen=%b pend=%b idle=%b, expected 0/0/1", f_wen, f_pending, f_idle);
      else n_pass++;
      f_qaddr = 5'd4;
      #1;
      n_total++;
      if (f_pending !== 1'b0) $display("FAIL flush_no_accept: got pending=%b, expected 0", f_pending);
      else n_pass++;
      for (int i = 0; i < 4; i++) tick();
      n_total++;
      if (f_q.size() != 0) $display("FAIL flush_drain: got %0d left, expected 0", f_q.size());
      else n_pass++;
      f_qaddr = '0;
   endtask

   task automatic test_rr();
      int a = 0;
      int b = 0;
      for (int cyc = 0; cyc < 60 && (a < 6 || b < 6); cyc++) begin
         logic acc0, acc1;
         r_valid[0] = (a < 6);
         r_waddr[0] = 5'(1 + a);  r_wdata[0] = 32'h100 + 32'(a);
         r_valid[1] = (b < 6);
         r_waddr[1] = 5'(16 + b); r_wdata[1] = 32'h200 + 32'(b);
         #1;
         acc0 = r_valid[0] && r_ready[0];
         acc1 = r_valid[1] && r_ready[1];
         if (acc0) r_q0.push_back({5'(1 + a), 32'h100 + 32'(a)});
         if (acc1) r_q1.push_back({5'(16 + b), 32'h200 + 32'(b)});
         tick();
         if (acc0) a++;
         if (acc1) b++;
      end
      r_valid = '0;
      for (int i = 0; i < 40 && r_idle !== 1'b1; i++) tick();
      tick();
      n_total++;
      if (r_seq.size() != 12 || r_q0.size() != 0 || r_q1.size() != 0)
         $display("FAIL rr_count: got %0d writes, %0d/%0d left, expected 12 writes 0/0 left",
                  r_seq.size(), r_q0.size(), r_q1.size());
      else n_pass++;
      if (r_seq.size() >= 8) begin
         for (int k = 0; k < 8; k++) begin
            n_total++;
            if (r_seq[k] !== k % 2)
               $display("FAIL rr_alt%0d: got ch%0d, expected ch%0d", k, r_seq[k], k % 2);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid();
      f_waddr[0] = 5'd6;  f_wdata[0] = 32'd6;
      f_waddr[1] = 5'd7;  f_wdata[1] = 32'd7;
      f_valid = 2'b11;
      tick();
      f_waddr[0] = 5'd14; f_wdata[0] = 32'd14;
      f_waddr[1] = 5'd15; f_wdata[1] = 32'd15;
      tick();  // x6 now on the write port
      rst = 1'b1;
      f_valid = '0;
      f_qaddr = 5'd7;
      #1;
      n_total++;
      if ({f_wen, f_raddr} !== 6'd0)
         $display("FAIL rstmid_port: got wen=%b x%0d, expected 0 x0", f_wen, f_raddr);
      else n_pass++;
      n_total++;
      if ({f_ready, f_idle, f_pending} !== 4'b1110)
         $display("FAIL rstmid_flags: got ready=%b idle=%b pend=%b, expected 11/1/0",
                  f_ready, f_idle, f_pending);
      else n_pass++;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      n_total++;
      if (f_idle !== 1'b1 || f_wen !== 1'b0)
         $display("FAIL rstmid_after: got idle=%b wen=%b, expected 1/0", f_idle, f_wen);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fixed_contention();
      test_full_x0();
      test_flush_query();
      test_rr();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
